serial_subtractor_alu: RTL and testbench

Bit-serial two's-complement subtractor that computes A − B one bit per clock, LSB first, and reports the same status flags as the combinational adder ALU: zero, negative, overflow, and carry/borrow. It is the inverse-direction companion to the ripple-carry adder. It serves area-constrained datapaths that can trade latency for a single full-adder slice. Operands are accepted with a start/busy/done handshake, and results are held in output registers until the next operation completes.

---
 rtl/serial_subtractor_alu.sv | 137 +++++++++++++
 tb/tb_serial_subtractor_alu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_alu.sv
// Bit-serial A-B (A + ~B + 1) through one full-adder slice with ALU flags; WIDTH cycles from accept to done.
// No queuing: start is ignored while busy, and a start held high through DONE chains the next operation.
module serial_subtractor_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             negf,
    output logic             zf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cmsb_q, cmsb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             negf_q, negf_d;
    logic             zf_q, zf_d;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;

    assign sum_bit   = sa_q[0] ^ sb_q[0] ^ c_q;
    assign carry_nxt = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
    assign res_nxt   = {sum_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        cmsb_d   = cmsb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        negf_d   = negf_q;
        zf_d     = zf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = ~b;
                    c_d     = 1'b1;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d = res_nxt;
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                c_d   = carry_nxt;
                cnt_d = cnt_q + CW'(1);
                // Carry into the MSB: compared against carry-out for signed overflow.
                if (cnt_q == PENULT_BIT) begin
                    cmsb_d = carry_nxt;
                end
                if (cnt_q == LAST_BIT) begin
                    diff_d   = res_nxt;
                    borrow_d = ~carry_nxt;
                    ovf_d    = cmsb_q ^ carry_nxt;
                    negf_d   = res_nxt[WIDTH-1] ^ (cmsb_q ^ carry_nxt);
                    zf_d     = ~|res_nxt;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            cmsb_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            negf_q   <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            cmsb_q   <= cmsb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            negf_q   <= negf_d;
            zf_q     <= zf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign negf   = negf_q;
    assign zf     = zf_q;

endmodule

// File: tb/tb_serial_subtractor_alu.sv
// Scoreboard bench for serial_subtractor_alu: expected flags queued at start, checked on every done pulse.
module tb_serial_subtractor_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         negf;
    logic         zf;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        logic         negf;
        logic         zf;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    serial_subtractor_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .negf   (negf),
        .zf     (zf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sx;
        int   sy;
        int   r;
        sx       = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy       = y[W-1] ? int'(y) - (1 << W) : int'(y);
        r        = sx - sy;
        e.diff   = x - y;
        e.borrow = (x < y);
        e.ovf    = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
        e.negf   = (r < 0);
        e.zf     = (e.diff == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (done === 1'b1) begin
            got = {diff, borrow, ovf, negf, zf};
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected_done got diff=%h b=%b v=%b n=%b z=%b",
                         got.diff, got.borrow, got.ovf, got.negf, got.zf);
            end else begin
                e = sb_q.pop_front();
                if (got !== e) begin
                    mismatched++;
                    $display("FAIL sb_result got diff=%h b=%b v=%b n=%b z=%b want diff=%h b=%b v=%b n=%b z=%b",
                             got.diff, got.borrow, got.ovf, got.negf, got.zf,
                             e.diff, e.borrow, e.ovf, e.negf, e.zf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the accepting edge with start low.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        start = 1'b1;
        a     = x;
        b     = y;
        if (push) sb_q.push_back(model(x, y));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        compared++;
        if ({busy, done, diff, borrow, ovf, negf, zf} !== '0) begin
            mismatched++;
            $display("FAIL reset_state got busy=%b done=%b diff=%h b=%b v=%b n=%b z=%b want all 0",
                     busy, done, diff, borrow, ovf, negf, zf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [10];
        logic [W-1:0] vb [10];
        int n;
        va = '{4'h5, 4'h3, 4'h7, 4'h8, 4'h6, 4'h8, 4'h0, 4'hF, 4'h0, 4'h0};
        vb = '{4'h3, 4'h5, 4'h8, 4'h1, 4'h6, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
        for (int i = 6; i < 10; i++) begin
            va[i] = W'($urandom_range(0, 15));
            vb[i] = W'($urandom_range(0, 15));
        end
        for (int i = 0; i < 10; i++) begin
            start_op(va[i], vb[i], 1'b1);
            compared++;
            if (busy !== 1'b1) begin
                mismatched++;
                $display("FAIL vec_busy[%0d] got %b want 1", i, busy);
            end
            wait_done(n);
            compared++;
            if (n !== W) begin
                mismatched++;
                $display("FAIL vec_latency[%0d] got %0d want %0d", i, n, W);
            end
            tick();
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL vec_done_pulse[%0d] got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n;
        start_op(4'h5, 4'h3, 1'b1);
        tick();
        start = 1'b1;
        a     = 4'h1;
        b     = 4'h7;
        tick();
        start = 1'b0;
        wait_done(n);
        compared++;
        if (n !== W - 2) begin
            mismatched++;
            $display("FAIL ignore_latency got %0d want %0d", n, W - 2);
        end
        tick();
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL ignore_no_second got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1;
        int   n;
        e1    = model(4'h9, 4'h4);
        start = 1'b1;
        a     = 4'h9;
        b     = 4'h4;
        sb_q.push_back(e1);
        tick();
        a = 4'h2;
        b = 4'h7;
        sb_q.push_back(model(4'h2, 4'h7));
        wait_done(n);
        compared++;
        if (n !== W) begin
            mismatched++;
            $display("FAIL b2b_first_latency got %0d want %0d", n, W);
        end
        tick();
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            compared++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== e1.diff || borrow !== e1.borrow) begin
                mismatched++;
                $display("FAIL b2b_stable[%0d] got busy=%b done=%b diff=%h b=%b want 1 0 %h %b",
                         k, busy, done, diff, borrow, e1.diff, e1.borrow);
            end
            tick();
        end
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_second_done got %b want 1", done);
        end
        tick();
        compared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_end got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start_op(4'h9, 4'h4, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        compared++;
        if ({busy, done, diff, borrow, ovf, negf, zf} !== '0) begin
            mismatched++;
            $display("FAIL midreset_outputs got busy=%b done=%b diff=%h b=%b v=%b n=%b z=%b want all 0",
                     busy, done, diff, borrow, ovf, negf, zf);
        end
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_idle got busy=%b done=%b want 0 0", busy, done);
        end
        start_op(4'h9, 4'h4, 1'b1);
        wait_done(n);
        compared++;
        if (n !== W) begin
            mismatched++;
            $display("FAIL midreset_latency got %0d want %0d", n, W);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        tick();
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
